// File: rtl/alu.sv
// alu: RV32 execute-stage integer ALU.
// Combinational result/zero/overflow plus registered result_q/zero_q.
// Optional feature: define ALU_DIVREM_EN to enable signed DIV (1100) and REM (1101);
// without it those codes return 0 like the other unused codes.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] result_q,
    output logic             zero_q
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_AND  = 4'b0011,
        OP_OR   = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_SLL  = 4'b0110,
        OP_SRL  = 4'b0111,
        OP_SRA  = 4'b1000,
        OP_SLT  = 4'b1001,
        OP_SLTU = 4'b1010,
        OP_PASB = 4'b1011,
        OP_DIV  = 4'b1100,
        OP_REM  = 4'b1101
    } alu_op_e;

    alu_op_e          op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign op    = alu_op_e'(alu_control);
    // Only the low bits of b select the shift distance; the rest are ignored.
    assign shamt = b[SHW-1:0];
    assign sum   = a + b;
    assign diff  = a - b;

`ifdef ALU_DIVREM_EN
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    // Signed divide/remainder with the RISC-V results for divide-by-zero and
    // MIN/-1 handled explicitly so the native operators never see those cases.
    always_comb begin
        quo = '0;
        rem = '0;
        if (b == '0) begin
            quo = ALL_ONES;
            rem = a;
        end else if (a == MIN_NEG && b == ALL_ONES) begin
            quo = a;
            rem = '0;
        end else begin
            quo = $signed(a) / $signed(b);
            rem = $signed(a) % $signed(b);
        end
    end
`endif

    // Operation select; unused codes fall through to zero.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = sum;
            OP_SUB:  result = diff;
            OP_MUL:  result = a * b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = WIDTH'($signed(a) >>> shamt);
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_PASB: result = b;
`ifdef ALU_DIVREM_EN
            OP_DIV:  result = quo;
            OP_REM:  result = rem;
`endif
            default: result = '0;
        endcase
    end

    // Signed overflow is only meaningful for ADD and SUB.
    always_comb begin
        overflow = 1'b0;
        case (op)
            OP_ADD:  overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
            OP_SUB:  overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            default: overflow = 1'b0;
        endcase
    end

    assign zero = (result == '0);

    // EX/MEM copies: cleared immediately on reset, released on the next clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            result_q <= result;
            zero_q   <= zero;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vectors for alu with hand-computed expectations.
// Build with ALU_DIVREM_EN defined to exercise the DIV/REM expectations.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_control;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic [31:0] result_q;
    logic        zero_q;

    int n_cmp = 0;
    int n_err = 0;

    alu #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .result      (result),
        .zero        (zero),
        .overflow    (overflow),
        .result_q    (result_q),
        .zero_q      (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one vector between edges, check the combinational outputs,
    // then check the registered copies one edge later.
    task automatic vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                       input logic [3:0] ctl, input logic [31:0] er,
                       input logic ez, input logic eo);
        @(negedge clk);
        a = va;
        b = vb;
        alu_control = ctl;
        #1;
        chk({tag, ".res"}, result, er);
        chk({tag, ".zero"}, {31'b0, zero}, {31'b0, ez});
        chk({tag, ".ovf"}, {31'b0, overflow}, {31'b0, eo});
        @(posedge clk);
        #1;
        chk({tag, ".res_q"}, result_q, er);
        chk({tag, ".zero_q"}, {31'b0, zero_q}, {31'b0, ez});
    endtask

    initial begin
        rst_n = 1'b0;
        a = 32'd0;
        b = 32'd0;
        alu_control = 4'b0000;

        // Reset state: registered outputs held at 0 even though zero=1 combinationally.
        @(posedge clk);
        #1;
        chk("rst.res_q", result_q, 32'h0);
        chk("rst.zero_q", {31'b0, zero_q}, 32'h0);
        chk("rst.zero_live", {31'b0, zero}, 32'h1);

        @(negedge clk);
        rst_n = 1'b1;

        vec("add",      32'd10,         32'd20,         4'b0000, 32'd30,         1'b0, 1'b0);
        vec("sub",      32'd30,         32'd10,         4'b0001, 32'd20,         1'b0, 1'b0);
        vec("sub_z",    32'd10,         32'd10,         4'b0001, 32'd0,          1'b1, 1'b0);
        vec("mul",      32'd10,         32'd20,         4'b0010, 32'd200,        1'b0, 1'b0);
        vec("mul_wrap", 32'h0001_0000,  32'h0001_0000,  4'b0010, 32'h0,          1'b1, 1'b0);
        vec("add_ovf",  32'h7FFF_FFFF,  32'd1,          4'b0000, 32'h8000_0000,  1'b0, 1'b1);
        vec("add_wrap", 32'hFFFF_FFFF,  32'd1,          4'b0000, 32'h0,          1'b1, 1'b0);
        vec("sub_ovf1", 32'h8000_0000,  32'd1,          4'b0001, 32'h7FFF_FFFF,  1'b0, 1'b1);
        vec("sub_ovf2", 32'h0,          32'h8000_0000,  4'b0001, 32'h8000_0000,  1'b0, 1'b1);
        vec("sub_neg",  32'd5,          32'd7,          4'b0001, 32'hFFFF_FFFE,  1'b0, 1'b0);
        vec("and",      32'hF0F0_1234,  32'h0FF0_FF00,  4'b0011, 32'h00F0_1200,  1'b0, 1'b0);
        vec("or",       32'hF0F0_1234,  32'h0FF0_FF00,  4'b0100, 32'hFFF0_FF34,  1'b0, 1'b0);
        vec("xor",      32'hF0F0_1234,  32'h0FF0_FF00,  4'b0101, 32'hFF00_ED34,  1'b0, 1'b0);
        vec("sll_hi",   32'd1,          32'hFFFF_FFE4,  4'b0110, 32'h10,         1'b0, 1'b0);
        vec("sll_0",    32'h1234_5678,  32'h20,         4'b0110, 32'h1234_5678,  1'b0, 1'b0);
        vec("srl",      32'hF000_0000,  32'd4,          4'b0111, 32'h0F00_0000,  1'b0, 1'b0);
        vec("srl_31",   32'h8000_0000,  32'd31,         4'b0111, 32'h1,          1'b0, 1'b0);
        vec("sra_31",   32'h8000_0000,  32'd31,         4'b1000, 32'hFFFF_FFFF,  1'b0, 1'b0);
        vec("sra_pos",  32'h4000_0000,  32'd4,          4'b1000, 32'h0400_0000,  1'b0, 1'b0);
        vec("slt",      32'hFFFF_FFFF,  32'd1,          4'b1001, 32'h1,          1'b0, 1'b0);
        vec("sltu",     32'hFFFF_FFFF,  32'd1,          4'b1010, 32'h0,          1'b1, 1'b0);
        vec("slt_r",    32'd1,          32'hFFFF_FFFF,  4'b1001, 32'h0,          1'b1, 1'b0);
        vec("sltu_r",   32'd1,          32'hFFFF_FFFF,  4'b1010, 32'h1,          1'b0, 1'b0);
        vec("passb",    32'h1111_1111,  32'hDEAD_BEEF,  4'b1011, 32'hDEAD_BEEF,  1'b0, 1'b0);
        vec("op_e",     32'h1234_5678,  32'h9ABC_DEF0,  4'b1110, 32'h0,          1'b1, 1'b0);
        vec("op_f",     32'h7FFF_FFFF,  32'd1,          4'b1111, 32'h0,          1'b1, 1'b0);
`ifdef ALU_DIVREM_EN
        vec("div_z",    32'd7,          32'd0,          4'b1100, 32'hFFFF_FFFF,  1'b0, 1'b0);
        vec("rem_neg",  32'hFFFF_FFF9,  32'd2,          4'b1101, 32'hFFFF_FFFF,  1'b0, 1'b0);
        vec("div_neg",  32'hFFFF_FFF9,  32'd2,          4'b1100, 32'hFFFF_FFFD,  1'b0, 1'b0);
        vec("rem_z",    32'd7,          32'd0,          4'b1101, 32'd7,          1'b0, 1'b0);
        vec("div_ovf",  32'h8000_0000,  32'hFFFF_FFFF,  4'b1100, 32'h8000_0000,  1'b0, 1'b0);
        vec("rem_ovf",  32'h8000_0000,  32'hFFFF_FFFF,  4'b1101, 32'h0,          1'b1, 1'b0);
`else
        vec("div_off",  32'd7,          32'd2,          4'b1100, 32'h0,          1'b1, 1'b0);
        vec("rem_off",  32'hFFFF_FFF9,  32'd2,          4'b1101, 32'h0,          1'b1, 1'b0);
`endif

        // Asynchronous reset mid-cycle: registered outputs clear at once, result stays live.
        vec("pre_rst",  32'd10,         32'd20,         4'b0000, 32'd30,         1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst.res_q", result_q, 32'h0);
        chk("arst.zero_q", {31'b0, zero_q}, 32'h0);
        chk("arst.res_live", result, 32'd30);
        @(posedge clk);
        #1;
        chk("arst.hold", result_q, 32'h0);

        // Release between edges; the next edge captures the live result.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel.before", result_q, 32'h0);
        @(posedge clk);
        #1;
        chk("rel.after", result_q, 32'd30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
